uart_tx_frame_ctrl: RTL
=======================

# uart_tx_frame_ctrl

Parametrised UART transmit frame controller. It accepts a parallel word over a valid/ready handshake and serialises it onto the TX line as start, data (LSB first), optional parity and 1 or 2 stop bits, each bit held for OVERSAMPLE baud ticks. It sits between the TX data source and the baud-tick generator and drives the line directly. It supports back-to-back frames with no idle gap.

## Interface
- DATA_BITS, 8, data bits per frame; legal range 5..9
- OVERSAMPLE, 16, counter_tick pulses per bit; legal range ≥2
- PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2

- clk  in  1  single clock; all logic on rising edge
- areset_n  in  1  reset, synchronous, active-low
- counter_tick  in  1  one-cycle baud×OVERSAMPLE enable pulse
- tx_data  in  DATA_BITS  word to send; sampled only on accept
- tx_valid  in  1  source has a word
- tx_ready  out  1  controller can accept; accept = tx_valid & tx_ready
- tx  out  1  serial line, registered, idle high
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse on the final tick of the last stop bit

## Operation
- States: IDLE, START, DATA, PARITY, STOP. PARITY is skipped when PARITY_MODE=0.
- Counters:
  - s: tick counter, width $clog2(OVERSAMPLE), counts 0..OVERSAMPLE-1.
  - n: bit counter, 4 bits, indexes data bits and stop bits.
  - shreg: DATA_BITS-wide shift register.
- IDLE:
  - tx=1, tx_ready=1. counter_tick is ignored.
  - On accept: load shreg←tx_data; compute parity (even = ^tx_data, odd = ~^tx_data) and register it; set s=0, n=0; go to START.
- Bit end = counter_tick while s==OVERSAMPLE-1. Any other tick increments s. Non-tick cycles hold all state.
- START: tx=0. On bit end: s=0, go to DATA.
- DATA:
  - tx=shreg[0].
  - On bit end: shift shreg right and n←n+1.
  - After bit DATA_BITS-1: n=0, go to PARITY, or to STOP when PARITY_MODE=0.
- PARITY: tx=parity bit. On bit end: go to STOP.
- STOP:
  - tx=1.
  - On bit end with n<STOP_BITS-1: n←n+1.
  - On bit end of the last stop bit: done=1 and tx_ready=1 for that cycle.
    - If tx_valid is high: accept, reload as in IDLE, go to START.
    - Otherwise go to IDLE.
- tx_ready is 0 in START/DATA/PARITY and in STOP except on the last-stop bit-end cycle. tx_valid outside an accept cycle has no effect, and tx_data changes mid-frame do not alter the frame.
- tx is a register loaded from the next-state line value. The line transition therefore appears on the edge that enters the new state.
- Illegal parameter values: elaboration fails via a generate-time $error.

## Timing
- Reset:
  - Any edge with areset_n=0 sets state=IDLE, s=0, n=0, shreg=0, tx=1. busy=0 and done=0 follow from state IDLE.
  - tx_ready is gated to 0 while areset_n=0.
  - Reset mid-frame aborts the frame: tx=1 from the next edge and no done pulse.
- Accept at edge k: tx=0 and busy=1 from edge k.
- Frame length = (1 + DATA_BITS + (PARITY_MODE≠0) + STOP_BITS) × OVERSAMPLE ticks, counted from the accept edge.
- done and tx_ready are combinational in the final tick cycle. busy stays high through that cycle.
- Back-to-back: the next start bit begins on the edge after the final stop tick, so the line is never high for an extra bit.
- Simultaneous areset_n=0 and accept: reset wins and the word is not taken.

## Test plan
- Defaults, tick every cycle, send 0x55 → tx = 0,1,0,1,0,1,0,1,0,1, each bit 16 cycles; done at cycle 160; busy 160 cycles; then IDLE with tx=1.
- PARITY_MODE=1 with 0x07 → parity bit 1. PARITY_MODE=2 with 0x07 → parity bit 0. Frame = 176 ticks.
- STOP_BITS=2, DATA_BITS=7, OVERSAMPLE=8, send 0x41 → line 0,1,0,0,0,0,0,1,1,1 at 8 ticks each; done at tick 80.
- tx_valid held high with 0xA3 then 0x3C → two frames contiguous; second start bit begins the cycle after the first done; done pulses 160 ticks apart; tx_ready high only in those cycles (plus the initial IDLE).
- counter_tick every 4th cycle, send 0xFF, change tx_data to 0x00 at tick 40 → data bits all 1; frame spans 640 cycles.
- areset_n low for 1 cycle at tick 50 of a frame → tx=1, busy=0 on that edge; no done; next accept starts a clean frame.

Source files
------------

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: serialises a handshaked parallel word as
// start, LSB-first data, optional parity and 1/2 stop bits, OVERSAMPLE ticks per bit.
`timescale 1ns / 1ps

module uart_tx_frame_ctrl #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned PARITY_MODE = 0,
  parameter int unsigned STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 counter_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned SW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [SW-1:0] SLast = SW'(OVERSAMPLE - 1);
  localparam logic [3:0] NDataLast = 4'(DATA_BITS - 1);
  localparam logic [3:0] NStopLast = 4'(STOP_BITS - 1);
  localparam bit HasParity = (PARITY_MODE != 0);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 2 || PARITY_MODE > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_param
    $error("uart_tx_frame_ctrl: illegal parameter value");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               state_q;
  logic [SW-1:0]        s_q;
  logic [3:0]           n_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_q;
  logic                 tx_q;

  logic bit_end;
  logic last_stop;
  logic accept;
  logic parity_new;

  assign bit_end    = counter_tick && (s_q == SLast);
  assign last_stop  = (state_q == StStop) && bit_end && (n_q == NStopLast);
  // Ready is offered on the last stop tick too, so a waiting word chains with no idle gap.
  assign tx_ready   = areset_n && ((state_q == StIdle) || last_stop);
  assign done       = areset_n && last_stop;
  assign accept     = tx_valid && tx_ready;
  assign busy       = (state_q != StIdle);
  assign tx         = tx_q;
  assign parity_new = (PARITY_MODE == 2) ? ~^tx_data : ^tx_data;

  // tx_q is loaded with the line value of the state being entered.
  always_ff @(posedge clk) begin
    if (!areset_n) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else if (accept) begin
      state_q <= StStart;
      s_q     <= '0;
      n_q     <= '0;
      shreg_q <= tx_data;
      par_q   <= parity_new;
      tx_q    <= 1'b0;
    end else if (counter_tick && (state_q != StIdle)) begin
      if (!bit_end) begin
        s_q <= s_q + SW'(1);
      end else begin
        s_q <= '0;
        unique case (state_q)
          StStart: begin
            state_q <= StData;
            tx_q    <= shreg_q[0];
          end
          StData: begin
            shreg_q <= shreg_q >> 1;
            if (n_q == NDataLast) begin
              n_q <= '0;
              if (HasParity) begin
                state_q <= StParity;
                tx_q    <= par_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
              end
            end else begin
              n_q  <= n_q + 4'd1;
              tx_q <= shreg_q[1];
            end
          end
          StParity: begin
            state_q <= StStop;
            tx_q    <= 1'b1;
          end
          StStop: begin
            tx_q <= 1'b1;
            if (n_q == NStopLast) begin
              state_q <= StIdle;
              n_q     <= '0;
            end else begin
              n_q <= n_q + 4'd1;
            end
          end
          default: begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
